// File: rtl/entry_capture.sv
// entry_capture: collects the player's colour entries during the entry phase.
// Buttons are synchronised, debounced and encoded to a 2-bit colour. Each
// accepted press produces a one-cycle entry_valid with its sequence index.
// Completion (done) follows level+1 entries; a stalled player yields timeout.
//
// Handshake: entry_valid, done and timeout are single-cycle registered pulses
// with no back-pressure; the consumer must sample them in the cycle they are
// high. entry_num and entry_index are meaningful whenever entry_valid is high.
module entry_capture #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on_off,
    input  logic [3:0] level,
    input  logic [3:0] sw,
    output logic [1:0] entry_num,
    output logic       entry_valid,
    output logic [3:0] entry_index,
    output logic [9:0] led,
    output logic       done,
    output logic       timeout,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRESS = 3'd1,
        DB_PRESS   = 3'd2,
        WAIT_REL   = 3'd3,
        DB_REL     = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [3:0]      sw_meta, sw_s;
    logic            on_off_q;
    logic [3:0]      pat, pat_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic [TM_W-1:0] timer, timer_n;
    logic            arm_rel, arm_rel_n;

    logic [1:0]      entry_num_n;
    logic            entry_valid_n;
    logic [3:0]      entry_index_n;
    logic [9:0]      led_n;
    logic            done_n;
    logic            timeout_n;
    logic            busy_n;
    logic            sw_valid;

    function automatic logic [1:0] encode(input logic [3:0] p);
        logic [1:0] c;
        case (p)
            4'b0010: c = 2'd1;
            4'b0100: c = 2'd2;
            4'b1000: c = 2'd3;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    // Exactly one button down counts as a press; none or several never does.
    assign sw_valid  = (sw_s != 4'd0) && ((sw_s & (sw_s - 4'd1)) == 4'd0);
    assign state_dbg = state;

    // Two-flop synchroniser for the buttons plus a delayed on_off for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta  <= 4'd0;
            sw_s     <= 4'd0;
            on_off_q <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            on_off_q <= on_off;
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat         <= 4'd0;
            db_cnt      <= '0;
            timer       <= '0;
            arm_rel     <= 1'b0;
            entry_num   <= 2'd0;
            entry_valid <= 1'b0;
            entry_index <= 4'd0;
            led         <= 10'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            pat         <= pat_n;
            db_cnt      <= db_cnt_n;
            timer       <= timer_n;
            arm_rel     <= arm_rel_n;
            entry_num   <= entry_num_n;
            entry_valid <= entry_valid_n;
            entry_index <= entry_index_n;
            led         <= led_n;
            done        <= done_n;
            timeout     <= timeout_n;
            busy        <= busy_n;
        end
    end

    // Next-state and next-output logic; outputs derive from the next state so they stay registered.
    always_comb begin
        state_n       = state;
        pat_n         = pat;
        db_cnt_n      = db_cnt;
        timer_n       = timer;
        arm_rel_n     = arm_rel;
        entry_num_n   = entry_num;
        entry_valid_n = 1'b0;
        entry_index_n = entry_index;
        done_n        = 1'b0;
        timeout_n     = 1'b0;

        if (!on_off) begin
            // Leaving the entry phase aborts silently from any state.
            state_n   = IDLE;
            arm_rel_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // on_off is high here, so a low delayed copy marks a rising edge.
                    if (!on_off_q) begin
                        entry_index_n = 4'd0;
                        timer_n       = '0;
                        db_cnt_n      = '0;
                        if (sw_s != 4'd0) begin
                            // A button already down must be released before it can count.
                            state_n   = WAIT_REL;
                            pat_n     = sw_s;
                            arm_rel_n = 1'b1;
                        end else begin
                            state_n = WAIT_PRESS;
                        end
                    end
                end
                WAIT_PRESS: begin
                    if (sw_valid) begin
                        state_n  = DB_PRESS;
                        pat_n    = sw_s;
                        db_cnt_n = '0;
                    end else if (timer == TM_LAST) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (sw_s != pat) begin
                        // Bounce: keep the stall timer running from where it was.
                        state_n = WAIT_PRESS;
                    end else if (db_cnt == DB_LAST) begin
                        entry_valid_n = 1'b1;
                        entry_num_n   = encode(pat);
                        timer_n       = '0;
                        state_n       = WAIT_REL;
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (sw_s == 4'd0) begin
                        state_n  = DB_REL;
                        db_cnt_n = '0;
                    end
                end
                DB_REL: begin
                    if (sw_s != 4'd0) begin
                        state_n = WAIT_REL;
                    end else if (db_cnt == DB_LAST) begin
                        if (arm_rel) begin
                            arm_rel_n = 1'b0;
                            timer_n   = '0;
                            state_n   = WAIT_PRESS;
                        end else if (entry_index == level) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            entry_index_n = entry_index + 4'd1;
                            timer_n       = '0;
                            state_n       = WAIT_PRESS;
                        end
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
        led_n  = {busy_n, 5'd0,
                  ((state_n == WAIT_REL) || (state_n == DB_REL)) ? pat_n : 4'd0};
    end

endmodule

// File: tb/tb_entry_capture.sv
// Directed bench for entry_capture with short debounce and timeout settings.
module tb_entry_capture;

    localparam int DB = 4;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       on_off;
    logic [3:0] level;
    logic [3:0] sw;
    logic [1:0] entry_num;
    logic       entry_valid;
    logic [3:0] entry_index;
    logic [9:0] led;
    logic       done;
    logic       timeout;
    logic       busy;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int ent_cnt = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    int ent0, done0, to0;

    // Expected entries as {entry_index, entry_num}
    logic [5:0] exp_q[$];

    entry_capture #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .on_off     (on_off),
        .level      (level),
        .sw         (sw),
        .entry_num  (entry_num),
        .entry_valid(entry_valid),
        .entry_index(entry_index),
        .led        (led),
        .done       (done),
        .timeout    (timeout),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [3:0] lvl);
        on_off = 1'b0;
        tick(2);
        level  = lvl;
        on_off = 1'b1;
        tick(1);
    endtask

    task automatic enter(input logic [3:0] pat, input logic [3:0] idx, input logic [1:0] num);
        exp_q.push_back({idx, num});
        sw = pat;
        tick(10);
        sw = 4'd0;
        tick(10);
    endtask

    task automatic snap();
        ent0  = ent_cnt;
        done0 = done_cnt;
        to0   = to_cnt;
    endtask

    // Scoreboard: every entry pulse is matched against the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (entry_valid) begin
                ent_cnt++;
                if (exp_q.size() == 0) begin
                    check("entry_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    check("entry_idx", 32'(entry_index), 32'(e[5:2]));
                    check("entry_num", 32'(entry_num), 32'(e[1:0]));
                end
                if (done) check("valid_with_done", 32'(done), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (timeout) check("done_with_timeout", 32'(timeout), 32'd0);
            end
            if (timeout) to_cnt++;
        end
    end

    initial begin
        reset  = 1'b1;
        on_off = 1'b0;
        level  = 4'd0;
        sw     = 4'd0;
        tick(2);
        check("rst_entry_num", 32'(entry_num), 32'd0);
        check("rst_entry_valid", 32'(entry_valid), 32'd0);
        check("rst_entry_index", 32'(entry_index), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_done_timeout_busy", {29'd0, done, timeout, busy}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic entry, exact press and release latency
        arm(4'd0);
        check("s1_busy_armed", 32'(busy), 32'd1);
        check("s1_state_wait_press", 32'(state_dbg), 32'd1);
        sw = 4'b0100;
        exp_q.push_back({4'd0, 2'd2});
        tick(6);
        check("s1_valid_early", 32'(entry_valid), 32'd0);
        tick(1);
        check("s1_valid_on_time", 32'(entry_valid), 32'd1);
        check("s1_led_held", 32'(led), 32'h204);
        tick(1);
        check("s1_valid_one_cycle", 32'(entry_valid), 32'd0);
        tick(2);
        sw = 4'd0;
        tick(6);
        check("s1_done_early", 32'(done), 32'd0);
        tick(1);
        check("s1_done_on_time", 32'(done), 32'd1);
        check("s1_busy_with_done", 32'(busy), 32'd0);
        check("s1_led_idle", 32'(led), 32'd0);
        tick(1);
        check("s1_done_one_cycle", 32'(done), 32'd0);

        // Multi-entry, level 2
        snap();
        arm(4'd2);
        enter(4'b0001, 4'd0, 2'd0);
        check("s2_index_after_1", 32'(entry_index), 32'd1);
        enter(4'b1000, 4'd1, 2'd3);
        enter(4'b0010, 4'd2, 2'd1);
        check("s2_entries", 32'(ent_cnt - ent0), 32'd3);
        check("s2_done_once", 32'(done_cnt - done0), 32'd1);
        check("s2_index_final", 32'(entry_index), 32'd2);
        check("s2_busy", 32'(busy), 32'd0);

        // Bounce then stable hold
        snap();
        arm(4'd0);
        for (int i = 0; i < 5; i++) begin
            sw = 4'b0100;
            tick(2);
            sw = 4'd0;
            tick(2);
        end
        check("s3_no_entry_bounce", 32'(ent_cnt - ent0), 32'd0);
        sw = 4'b0100;
        exp_q.push_back({4'd0, 2'd2});
        tick(6);
        check("s3_valid_early", 32'(entry_valid), 32'd0);
        tick(1);
        check("s3_valid_on_time", 32'(entry_valid), 32'd1);
        tick(3);
        sw = 4'd0;
        tick(10);
        check("s3_entries", 32'(ent_cnt - ent0), 32'd1);
        check("s3_done", 32'(done_cnt - done0), 32'd1);

        // Invalid patterns, then stall timeout
        snap();
        arm(4'd0);
        sw = 4'b0110;
        tick(20);
        sw = 4'd0;
        tick(29);
        check("s4_timeout_early", 32'(timeout), 32'd0);
        tick(1);
        check("s4_timeout_on_time", 32'(timeout), 32'd1);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_done_low", 32'(done), 32'd0);
        tick(1);
        check("s4_timeout_one_cycle", 32'(timeout), 32'd0);
        tick(5);
        check("s4_no_entry", 32'(ent_cnt - ent0), 32'd0);
        check("s4_timeout_once", 32'(to_cnt - to0), 32'd1);

        // Abort during DB_PRESS, re-arm, hold-high after done
        arm(4'd1);
        enter(4'b0001, 4'd0, 2'd0);
        check("s5_index_1", 32'(entry_index), 32'd1);
        sw = 4'b1000;
        tick(4);
        check("s5_in_db_press", 32'(state_dbg), 32'd2);
        snap();
        on_off = 1'b0;
        tick(1);
        check("s5_abort_busy", 32'(busy), 32'd0);
        check("s5_abort_state", 32'(state_dbg), 32'd0);
        tick(8);
        sw = 4'd0;
        tick(4);
        check("s5_abort_no_pulse", 32'((ent_cnt - ent0) + (done_cnt - done0) + (to_cnt - to0)), 32'd0);
        check("s5_index_held", 32'(entry_index), 32'd1);
        on_off = 1'b1;
        tick(1);
        check("s5_rearm_index", 32'(entry_index), 32'd0);
        check("s5_rearm_busy", 32'(busy), 32'd1);
        enter(4'b0100, 4'd0, 2'd2);
        enter(4'b0001, 4'd1, 2'd0);
        check("s5_done", 32'(done_cnt - done0), 32'd1);
        snap();
        tick(10);
        sw = 4'b0001;
        tick(10);
        sw = 4'd0;
        tick(10);
        check("s5_no_rearm_busy", 32'(busy), 32'd0);
        check("s5_no_rearm_entry", 32'(ent_cnt - ent0), 32'd0);

        // Held at arm, then async reset in DB_REL
        snap();
        on_off = 1'b0;
        tick(2);
        level = 4'd0;
        sw = 4'b0001;
        tick(4);
        on_off = 1'b1;
        tick(1);
        check("s6_held_state", 32'(state_dbg), 32'd3);
        check("s6_held_led", 32'(led), 32'h201);
        tick(10);
        check("s6_held_no_entry", 32'(ent_cnt - ent0), 32'd0);
        sw = 4'd0;
        tick(10);
        check("s6_release_state", 32'(state_dbg), 32'd1);
        check("s6_release_index", 32'(entry_index), 32'd0);
        check("s6_release_no_done", 32'(done_cnt - done0), 32'd0);
        exp_q.push_back({4'd0, 2'd3});
        sw = 4'b1000;
        tick(10);
        check("s6_entry", 32'(ent_cnt - ent0), 32'd1);
        sw = 4'd0;
        tick(4);
        check("s6_in_db_rel", 32'(state_dbg), 32'd4);
        check("s6_num_before_rst", 32'(entry_num), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("s6_rst_entry_num", 32'(entry_num), 32'd0);
        check("s6_rst_led", 32'(led), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_state", 32'(state_dbg), 32'd0);
        check("s6_rst_pulses", {29'd0, entry_valid, done, timeout}, 32'd0);
        on_off = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);
        check("s6_no_done_after_rst", 32'(done_cnt - done0), 32'd0);
        check("s6_idle_after_rst", 32'(busy), 32'd0);

        // Totals
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("total_entries", 32'(ent_cnt), 32'd9);
        check("total_done", 32'(done_cnt), 32'd4);
        check("total_timeout", 32'(to_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/entry_capture.md
# entry_capture

Captures the player's answer sequence during the Simon Says entry phase. It is the receiving end of the sequence that the blinker displays. The block synchronises and debounces the four colour buttons and encodes each press into the same 2-bit colour code that is stored in mem. Each entry is handed to the comparator as a one-cycle valid pulse together with its sequence index. The block reports completion after level+1 entries, or a timeout if the player stalls.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a press or a release.
- TIMEOUT_CYCLES, default 250_000_000: maximum idle cycles allowed in WAIT_PRESS before timeout.
- clk  in  1: system clock, the only clock.
- reset  in  1: asynchronous, active-high; clears all state.
- on_off  in  1: entry-phase enable from fsm. A rising edge arms capture.
- level  in  4: current level; the block expects level+1 entries.
- sw  in  4: raw colour buttons, one-hot. sw[k] encodes to colour k.
- entry_num  out  2: encoded colour of the accepted entry. Valid only with entry_valid.
- entry_valid  out  1: one-cycle pulse per accepted entry.
- entry_index  out  4: index of the current or last entry, 0..level; drives the mem address during entry.
- led  out  10: led[3:0] echoes the held button; led[9] = busy; led[8:4] = 0.
- done  out  1: one-cycle pulse when all entries are captured.
- timeout  out  1: one-cycle pulse on player stall.
- busy  out  1: high in every state except IDLE.

## Operation
- sw passes through a 2-flop synchroniser to give sw_s. A debounce counter of width $clog2(DEBOUNCE_CYCLES+1) clears on any change of sw_s.
- A pattern is valid when exactly one bit is set. Zero bits or multiple bits set is never a press.
- States: IDLE, WAIT_PRESS, DB_PRESS, WAIT_REL, DB_REL.
- IDLE -> WAIT_PRESS on an on_off rising edge, detected against a registered copy of on_off. On this transition: entry_index := 0, timer := 0.
- WAIT_PRESS:
  - A valid sw_s goes to DB_PRESS and latches the pattern.
  - The timer increments each cycle. When it reaches TIMEOUT_CYCLES-1: pulse timeout, go to IDLE.
- DB_PRESS:
  - If sw_s differs from the latched pattern, return to WAIT_PRESS. The timer is not cleared.
  - After DEBOUNCE_CYCLES stable cycles:
    - entry_valid := 1 and entry_num := encode(pattern).
    - Go to WAIT_REL. The timer is cleared.
- WAIT_REL: when sw_s == 0, go to DB_REL. Any other pattern keeps the state.
- DB_REL:
  - Nonzero sw_s returns to WAIT_REL.
  - After DEBOUNCE_CYCLES stable zero cycles:
    - If entry_index == level: pulse done, go to IDLE.
    - Otherwise: entry_index += 1, timer := 0, go to WAIT_PRESS.
- on_off low in any state forces IDLE on the next edge. No done, timeout or entry_valid is issued.
- After done or timeout, the block stays in IDLE until on_off falls and rises again. Holding on_off high does not re-arm it.
- entry_index holds its value in IDLE until the next arm.
- A button still held at arm time must first be released: the block does not treat a held button as a press. Implementation: on arm, if sw_s != 0, enter WAIT_REL instead of WAIT_PRESS. The release does not advance entry_index.
- level is sampled on each DB_REL completion. It must be stable while busy.
- Arithmetic:
  - entry_index is 4-bit unsigned. It cannot wrap, because the maximum is level = 15.
  - The timer is $clog2(TIMEOUT_CYCLES) bits and saturates by the transition to IDLE.

## Timing
- Reset values: entry_num = 0, entry_valid = 0, entry_index = 0, led = 0, done = 0, timeout = 0, busy = 0, state = IDLE, synchroniser = 0.
- All outputs are registered. No combinational path from sw to any output.
- Press latency: sw goes valid and stable at edge t → entry_valid is high for exactly the cycle after edge t+2+DEBOUNCE_CYCLES.
- Release latency: sw returns to 0 at edge t → entry_index increments, or done pulses, at edge t+2+DEBOUNCE_CYCLES.
- done and timeout are mutually exclusive. Each is exactly one cycle. busy falls in the same cycle that either pulses.
- entry_valid never occurs in the same cycle as done.
- led[3:0] equals the latched pattern in WAIT_REL and DB_REL, and is 0 otherwise.
- Reset asserted mid-entry: all outputs go to their reset values immediately (asynchronous). No pulse is issued.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
- **Basic entry:** arm with level=0; press sw=4'b0100 clean for 10 cycles, then release → one entry_valid with entry_num=2 and entry_index=0, arriving 6 cycles after the press; done pulses 6 cycles after the release; busy=0 afterwards.
- **Multi-entry:** level=2; press 0001, 1000, 0010 in turn, each with a clean release → entry_valid ×3 with entry_num 0,3,1 and entry_index 0,1,2; a single done pulse.
- **Bounce:** toggle 0100 on and off at 2-cycle intervals for 20 cycles, then hold → exactly one entry_valid, arriving 6 cycles after the final stable edge.
- **Invalid patterns:** hold 0110, then 0000 → no entry_valid. After 50 cycles in WAIT_PRESS, timeout pulses once, done=0, busy=0.
- **Abort and re-arm:** drop on_off during DB_PRESS → no pulses and busy=0 next cycle. Hold on_off high after done → no re-arm. Toggle on_off low then high → entry_index=0.
- **Held at arm and async reset:** arm with 0001 held → no entry until the button is released and pressed again. Assert reset mid-DB_REL → all outputs 0 in the same cycle.
